mef_ciclorega: RTL and testbench

MEF_CICLOREGA -- requirements
Module: mef_ciclorega

---
 rtl/mef_ciclorega.sv | 158 +++++++++++++++
 tb/tb_mef_ciclorega.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mef_ciclorega.sv
// Irrigation cycle controller: optional tank fill, valve settle, timed watering
// and cooldown, with a latched alarm for fill timeout or dry-run.
module mef_ciclorega #(
   parameter int unsigned T_PREP  = 2,
   parameter int unsigned T_ASP   = 16,
   parameter int unsigned T_GOT   = 32,
   parameter int unsigned T_PAUSA = 8,
   parameter int unsigned T_ENCHE = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic REGA,
   input  logic Asp,
   input  logic Got,
   input  logic Vazio,
   input  logic Cheio,
   input  logic Rec,
   output logic ValvAsp,
   output logic ValvGot,
   output logic Bomba,
   output logic Enche,
   output logic Alarme,
   output logic Ocupado,
   output logic Fim
);

   typedef enum logic [2:0] {
      OCIOSO  = 3'd0,
      ENCHE   = 3'd1,
      PREP    = 3'd2,
      REGANDO = 3'd3,
      PAUSA   = 3'd4,
      ERRO    = 3'd5
   } estado_t;

   localparam logic [7:0] LIM_PREP  = 8'(T_PREP - 1);
   localparam logic [7:0] LIM_ASP   = 8'(T_ASP - 1);
   localparam logic [7:0] LIM_GOT   = 8'(T_GOT - 1);
   localparam logic [7:0] LIM_PAUSA = 8'(T_PAUSA - 1);
   localparam logic [7:0] LIM_ENCHE = 8'(T_ENCHE - 1);

   estado_t    estado_q, estado_d;
   logic [7:0] cnt_q, cnt_d;
   logic       tipo_q, tipo_d;
   logic       fim_q, fim_d;
   logic [7:0] lim_rega_s;

   assign lim_rega_s = tipo_q ? LIM_GOT : LIM_ASP;

   // State, counter, type and completion-flag registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_q <= OCIOSO;
         cnt_q    <= 8'd0;
         tipo_q   <= 1'b0;
         fim_q    <= 1'b0;
      end else begin
         estado_q <= estado_d;
         cnt_q    <= cnt_d;
         tipo_q   <= tipo_d;
         fim_q    <= fim_d;
      end
   end

   // Next-state logic; Fim is registered so it only marks the first PAUSA cycle
   always_comb begin
      estado_d = estado_q;
      tipo_d   = tipo_q;
      fim_d    = 1'b0;
      case (estado_q)
         OCIOSO: begin
            if (REGA && (Asp || Got)) begin
               tipo_d   = ~Asp;
               estado_d = Vazio ? ENCHE : PREP;
            end else begin
               estado_d = OCIOSO;
            end
         end
         ENCHE: begin
            if (Cheio)                   estado_d = PREP;
            else if (cnt_q == LIM_ENCHE) estado_d = ERRO;
            else if (!REGA)              estado_d = PAUSA;
            else                         estado_d = ENCHE;
         end
         PREP: begin
            if (!REGA)                  estado_d = PAUSA;
            else if (cnt_q == LIM_PREP) estado_d = REGANDO;
            else                        estado_d = PREP;
         end
         REGANDO: begin
            if (Vazio) begin
               estado_d = ERRO;
            end else if (cnt_q == lim_rega_s) begin
               estado_d = PAUSA;
               fim_d    = 1'b1;
            end else if (!REGA) begin
               estado_d = PAUSA;
            end else begin
               estado_d = REGANDO;
            end
         end
         PAUSA: begin
            if (cnt_q == LIM_PAUSA) estado_d = OCIOSO;
            else                    estado_d = PAUSA;
         end
         ERRO: begin
            if (Rec && !REGA) estado_d = OCIOSO;
            else              estado_d = ERRO;
         end
         default: estado_d = OCIOSO;
      endcase

      if ((estado_d != estado_q) || (estado_q == OCIOSO) || (estado_q == ERRO)) begin
         cnt_d = 8'd0;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Moore output decode from registered state and type only
   always_comb begin
      ValvAsp = 1'b0;
      ValvGot = 1'b0;
      Bomba   = 1'b0;
      Enche   = 1'b0;
      Alarme  = 1'b0;
      Ocupado = 1'b0;
      Fim     = 1'b0;
      case (estado_q)
         ENCHE: begin
            Enche   = 1'b1;
            Ocupado = 1'b1;
         end
         PREP: begin
            ValvAsp = ~tipo_q;
            ValvGot = tipo_q;
            Ocupado = 1'b1;
         end
         REGANDO: begin
            ValvAsp = ~tipo_q;
            ValvGot = tipo_q;
            Bomba   = 1'b1;
            Ocupado = 1'b1;
         end
         PAUSA: begin
            Ocupado = 1'b1;
            Fim     = fim_q;
         end
         ERRO: begin
            Alarme = 1'b1;
         end
         default: begin
            Ocupado = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mef_ciclorega.sv
// Directed bench for mef_ciclorega with default timing parameters.
module tb_mef_ciclorega;

   logic clk, reset, REGA, Asp, Got, Vazio, Cheio, Rec;
   logic ValvAsp, ValvGot, Bomba, Enche, Alarme, Ocupado, Fim;
   logic [6:0] o;
   int n_chk = 0;
   int n_pass = 0;

   // {ValvAsp, ValvGot, Bomba, Enche, Alarme, Ocupado, Fim}
   localparam logic [6:0] IDLE    = 7'b0000000;
   localparam logic [6:0] PREP_A  = 7'b1000010;
   localparam logic [6:0] PREP_G  = 7'b0100010;
   localparam logic [6:0] REG_A   = 7'b1010010;
   localparam logic [6:0] REG_G   = 7'b0110010;
   localparam logic [6:0] FILL    = 7'b0001010;
   localparam logic [6:0] PAUSE   = 7'b0000010;
   localparam logic [6:0] PAUSE_F = 7'b0000011;
   localparam logic [6:0] ALARM   = 7'b0000100;

   assign o = {ValvAsp, ValvGot, Bomba, Enche, Alarme, Ocupado, Fim};

   mef_ciclorega dut (
      .clk(clk), .reset(reset), .REGA(REGA), .Asp(Asp), .Got(Got),
      .Vazio(Vazio), .Cheio(Cheio), .Rec(Rec),
      .ValvAsp(ValvAsp), .ValvGot(ValvGot), .Bomba(Bomba), .Enche(Enche),
      .Alarme(Alarme), .Ocupado(Ocupado), .Fim(Fim)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      REGA = 1'b0; Asp = 1'b0; Got = 1'b0; Vazio = 1'b0; Cheio = 1'b0; Rec = 1'b1;
      repeat (12) step();
      Rec = 1'b0;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b0; REGA = 1'b0; Asp = 1'b0; Got = 1'b0;
      Vazio = 1'b0; Cheio = 1'b0; Rec = 1'b0;
      step();
      n_chk++; if (o !== IDLE) $display("FAIL reset_state got %b want %b", o, IDLE); else n_pass++;
      reset = 1'b1; REGA = 1'b1;
      step();
      n_chk++; if (o !== IDLE) $display("FAIL idle_no_type got %b want %b", o, IDLE); else n_pass++;
      REGA = 1'b0;
   endtask

   task automatic test_asp();
      REGA = 1'b1; Asp = 1'b1; Got = 1'b0; Vazio = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         n_chk++; if (o !== PREP_A) $display("FAIL asp_prep c%0d got %b want %b", i, o, PREP_A); else n_pass++;
         if (i == 0) begin Asp = 1'b0; Got = 1'b1; end
      end
      for (int i = 0; i < 16; i++) begin
         step();
         n_chk++; if (o !== REG_A) $display("FAIL asp_water c%0d got %b want %b", i, o, REG_A); else n_pass++;
      end
      step();
      n_chk++; if (o !== PAUSE_F) $display("FAIL asp_fim got %b want %b", o, PAUSE_F); else n_pass++;
      REGA = 1'b0; Got = 1'b0;
      for (int i = 1; i < 8; i++) begin
         step();
         n_chk++; if (o !== PAUSE) $display("FAIL asp_pause c%0d got %b want %b", i, o, PAUSE); else n_pass++;
      end
      for (int i = 0; i < 2; i++) begin
         step();
         n_chk++; if (o !== IDLE) $display("FAIL asp_idle c%0d got %b want %b", i, o, IDLE); else n_pass++;
      end
   endtask

   task automatic test_got_fill();
      REGA = 1'b1; Got = 1'b1; Asp = 1'b0; Vazio = 1'b1; Cheio = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         n_chk++; if (o !== FILL) $display("FAIL fill c%0d got %b want %b", i, o, FILL); else n_pass++;
      end
      Cheio = 1'b1; Vazio = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         n_chk++; if (o !== PREP_G) $display("FAIL got_prep c%0d got %b want %b", i, o, PREP_G); else n_pass++;
         Cheio = 1'b0;
      end
      for (int i = 0; i < 32; i++) begin
         step();
         n_chk++; if (o !== REG_G) $display("FAIL got_water c%0d got %b want %b", i, o, REG_G); else n_pass++;
      end
      step();
      n_chk++; if (o !== PAUSE_F) $display("FAIL got_fim got %b want %b", o, PAUSE_F); else n_pass++;
      go_idle();
   endtask

   task automatic test_fill_timeout();
      REGA = 1'b1; Asp = 1'b1; Got = 1'b0; Vazio = 1'b1; Cheio = 1'b0;
      for (int i = 0; i < 64; i++) begin
         step();
         n_chk++; if (o !== FILL) $display("FAIL timeout_fill c%0d got %b want %b", i, o, FILL); else n_pass++;
      end
      step();
      n_chk++; if (o !== ALARM) $display("FAIL timeout_erro got %b want %b", o, ALARM); else n_pass++;
      Vazio = 1'b0; Rec = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_chk++; if (o !== ALARM) $display("FAIL rec_with_rega c%0d got %b want %b", i, o, ALARM); else n_pass++;
      end
      Rec = 1'b0; REGA = 1'b0; Asp = 1'b0;
      step();
      n_chk++; if (o !== ALARM) $display("FAIL no_rec got %b want %b", o, ALARM); else n_pass++;
      Rec = 1'b1;
      step();
      n_chk++; if (o !== IDLE) $display("FAIL rec_clear got %b want %b", o, IDLE); else n_pass++;
      Rec = 1'b0;
   endtask

   task automatic test_dry_run();
      REGA = 1'b1; Asp = 1'b1; Got = 1'b0; Vazio = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         n_chk++; if (o !== PREP_A) $display("FAIL dry_prep c%0d got %b want %b", i, o, PREP_A); else n_pass++;
      end
      for (int i = 0; i < 5; i++) begin
         step();
         n_chk++; if (o !== REG_A) $display("FAIL dry_water c%0d got %b want %b", i, o, REG_A); else n_pass++;
      end
      Vazio = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_chk++; if (o !== ALARM) $display("FAIL dry_erro c%0d got %b want %b", i, o, ALARM); else n_pass++;
      end
      go_idle();
   endtask

   task automatic test_rega_drop();
      REGA = 1'b1; Got = 1'b1; Asp = 1'b0; Vazio = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         n_chk++; if (o !== PREP_G) $display("FAIL drop_prep c%0d got %b want %b", i, o, PREP_G); else n_pass++;
      end
      for (int i = 0; i < 3; i++) begin
         step();
         n_chk++; if (o !== REG_G) $display("FAIL drop_water c%0d got %b want %b", i, o, REG_G); else n_pass++;
      end
      REGA = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         n_chk++; if (o !== PAUSE) $display("FAIL drop_pause c%0d got %b want %b", i, o, PAUSE); else n_pass++;
         if (i == 1) REGA = 1'b1;
      end
      step();
      n_chk++; if (o !== IDLE) $display("FAIL drop_idle got %b want %b", o, IDLE); else n_pass++;
      step();
      n_chk++; if (o !== PREP_G) $display("FAIL drop_restart got %b want %b", o, PREP_G); else n_pass++;
      go_idle();
   endtask

   task automatic test_reset_mid();
      REGA = 1'b1; Asp = 1'b1; Got = 1'b1; Vazio = 1'b0;
      step();
      n_chk++; if (o !== PREP_A) $display("FAIL both_prep got %b want %b", o, PREP_A); else n_pass++;
      step();
      step();
      n_chk++; if (o !== REG_A) $display("FAIL both_water got %b want %b", o, REG_A); else n_pass++;
      step();
      #2 reset = 1'b0;
      #1;
      n_chk++; if (o !== IDLE) $display("FAIL async_reset got %b want %b", o, IDLE); else n_pass++;
      #1 reset = 1'b1;
      step();
      n_chk++; if (o !== PREP_A) $display("FAIL first_edge got %b want %b", o, PREP_A); else n_pass++;
      go_idle();
   endtask

   initial begin
      test_reset();
      test_asp();
      test_got_fill();
      test_fill_timeout();
      test_dry_run();
      test_rega_drop();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
